fetch_unit: RTL and testbench

- Instruction fetch stage sitting directly upstream of the dual-port memory's instruction port.
- Acts as bus master on ibus, issuing word reads at a sequential PC and buffering returned words in a small prefetch FIFO.
- Hands instructions to the decoder over a valid/ready handshake.
- Redirect (branch/jump/trap) flushes the queue and restarts fetch, discarding any in-flight response.

---
 rtl/bus_pkg.sv | 15 +
 rtl/fetch_pkg.sv | 19 +
 rtl/fetch_unit_if.sv | 22 ++
 rtl/fetch_unit_fifo.sv | 74 +++++++
 rtl/fetch_unit.sv | 144 ++++++++++++++
 tb/tb_fetch_unit.sv | 287 ++++++++++++++++++++++++++++
 6 files changed

// File: rtl/bus_pkg.sv
// Shared bus attribute types for the memory-side master/slave bus.
package bus_pkg;

  typedef enum logic {
    READ  = 1'b0,
    WRITE = 1'b1
  } ttype_t;

  typedef enum logic [1:0] {
    BYTE = 2'd0,
    HALF = 2'd1,
    WORD = 2'd2
  } tsize_t;

endpackage

// File: rtl/fetch_pkg.sv
// Types and constants shared by the instruction fetch stage.
package fetch_pkg;

  localparam int unsigned INSTR_BYTES = 4;
  localparam int unsigned XLEN        = 32;

  typedef enum logic [1:0] {
    IDLE  = 2'd0,
    ISSUE = 2'd1,
    WAIT  = 2'd2,
    DRAIN = 2'd3
  } fetch_state_t;

  typedef struct packed {
    logic [XLEN-1:0] pc;
    logic [XLEN-1:0] instr;
  } fetch_entry_t;

endpackage

// File: rtl/fetch_unit_if.sv
// Memory bus between a master (fetch stage) and a memory slave port.
interface master_bus_if;

  logic               bstart;
  logic [31:0]        addr;
  logic               ss;
  bus_pkg::ttype_t    ttype;
  bus_pkg::tsize_t    tsize;
  logic               bdone;
  logic [31:0]        rdata;

  modport master (
    output bstart, addr, ss, ttype, tsize,
    input  bdone, rdata
  );

  modport slave (
    input  bstart, addr, ss, ttype, tsize,
    output bdone, rdata
  );

endinterface

// File: rtl/fetch_unit_fifo.sv
// Prefetch FIFO: power-of-two ring of {pc, instr} entries with flush.
module fetch_fifo
  import fetch_pkg::*;
#(
  parameter int unsigned DEPTH = 4,
  localparam int unsigned AW = $clog2(DEPTH),
  localparam int unsigned CW = AW + 1
) (
  input  logic          clk,
  input  logic          rst_n,
  input  logic          push,
  input  logic          pop,
  input  logic          flush,
  input  fetch_entry_t  wr_entry,
  output logic          full,
  output logic          empty,
  output logic [CW-1:0] count,
  output fetch_entry_t  head
);

  fetch_entry_t    mem [DEPTH];
  logic [AW-1:0]   rd_ptr;
  logic [AW-1:0]   wr_ptr;
  logic            pop_eff;
  logic            push_eff;
  logic [CW-1:0]   count_next;

  assign head = mem[rd_ptr];

  // Effective push/pop and next occupancy; flush dominates both.
  always_comb begin
    pop_eff    = pop && !empty;
    push_eff   = push && (!full || pop_eff);
    count_next = count;
    if (flush) begin
      count_next = '0;
    end else if (push_eff && !pop_eff) begin
      count_next = count + CW'(1);
    end else if (!push_eff && pop_eff) begin
      count_next = count - CW'(1);
    end
  end

  // Storage, pointers and registered occupancy flags.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      rd_ptr <= '0;
      wr_ptr <= '0;
      count  <= '0;
      empty  <= 1'b1;
      full   <= 1'b0;
      for (int i = 0; i < DEPTH; i++) begin
        mem[i] <= '0;
      end
    end else begin
      if (flush) begin
        rd_ptr <= '0;
        wr_ptr <= '0;
      end else begin
        if (push_eff) begin
          mem[wr_ptr] <= wr_entry;
          wr_ptr      <= wr_ptr + AW'(1);
        end
        if (pop_eff) begin
          rd_ptr <= rd_ptr + AW'(1);
        end
      end
      count <= count_next;
      empty <= (count_next == '0);
      full  <= (count_next == CW'(DEPTH));
    end
  end

endmodule

// File: rtl/fetch_unit.sv
// Instruction fetch stage: sequential word reads on ibus into a prefetch FIFO.
// Optional macro FETCH_PERF_EN adds perf_fetched / perf_stall counters.
module fetch_unit
  import fetch_pkg::*;
  import bus_pkg::*;
#(
  parameter logic [31:0] RESET_PC = 32'h0000_0000,
  parameter int unsigned DEPTH    = 4
) (
  input  logic         clk,
  input  logic         rst_n,
  master_bus_if.master ibus,
  input  logic         redirect_valid,
  input  logic [31:0]  redirect_pc,
  output logic         instr_valid,
  output logic [31:0]  instr,
  output logic [31:0]  instr_pc,
  input  logic         instr_ready
`ifdef FETCH_PERF_EN
  ,
  output logic [31:0]  perf_fetched,
  output logic [31:0]  perf_stall
`endif
);

  localparam int unsigned CW  = $clog2(DEPTH) + 1;
  localparam int unsigned CAW = CW + 1;

  localparam logic [1:0] ST_IDLE  = IDLE;
  localparam logic [1:0] ST_ISSUE = ISSUE;
  localparam logic [1:0] ST_WAIT  = WAIT;
  localparam logic [1:0] ST_DRAIN = DRAIN;

  logic [1:0]    state_q, state_d;
  logic [31:0]   fetch_pc_q, fetch_pc_d;
  logic          bstart_q;
  logic [31:0]   addr_q;
  logic          ss_q;

  logic          fifo_full, fifo_empty;
  logic [CW-1:0] fifo_count;
  fetch_entry_t  fifo_head, push_entry;
  logic          push, pop;
  logic [CAW-1:0] count_after;
  logic          credit_after;
  logic [31:0]   redirect_tgt;

  assign redirect_tgt = redirect_pc & ~32'h3;
  assign pop          = instr_valid && instr_ready && !redirect_valid;
  assign push         = (state_q == ST_WAIT) && ibus.bdone && !redirect_valid;
  assign push_entry   = '{pc: fetch_pc_q, instr: ibus.rdata};
  assign count_after  = CAW'(fifo_count) + CAW'(push) - CAW'(pop);
  assign credit_after = count_after < CAW'(DEPTH);

  fetch_fifo #(.DEPTH(DEPTH)) u_fifo (
    .clk      (clk),
    .rst_n    (rst_n),
    .push     (push),
    .pop      (pop),
    .flush    (redirect_valid),
    .wr_entry (push_entry),
    .full     (fifo_full),
    .empty    (fifo_empty),
    .count    (fifo_count),
    .head     (fifo_head)
  );

  assign instr_valid = !fifo_empty;
  assign instr       = fifo_head.instr;
  assign instr_pc    = fifo_head.pc;

  assign ibus.bstart = bstart_q;
  assign ibus.addr   = addr_q;
  assign ibus.ss     = ss_q;
  assign ibus.ttype  = READ;
  assign ibus.tsize  = WORD;

  // State register.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q    <= ST_IDLE;
      fetch_pc_q <= RESET_PC;
    end else begin
      state_q    <= state_d;
      fetch_pc_q <= fetch_pc_d;
    end
  end

  // Next state and next fetch PC; redirect always retargets the PC.
  always_comb begin
    state_d    = state_q;
    fetch_pc_d = fetch_pc_q;
    case (state_q)
      ST_IDLE: begin
        if (!redirect_valid && !fifo_full) state_d = ST_ISSUE;
      end
      ST_ISSUE: begin
        state_d = redirect_valid ? ST_DRAIN : ST_WAIT;
      end
      ST_WAIT: begin
        if (ibus.bdone) begin
          fetch_pc_d = fetch_pc_q + 32'(INSTR_BYTES);
          state_d    = (redirect_valid || credit_after) ? ST_ISSUE : ST_IDLE;
        end else if (redirect_valid) begin
          state_d = ST_DRAIN;
        end
      end
      ST_DRAIN: begin
        if (ibus.bdone) begin
          state_d = (redirect_valid || credit_after) ? ST_ISSUE : ST_IDLE;
        end
      end
      default: state_d = ST_IDLE;
    endcase
    if (redirect_valid) fetch_pc_d = redirect_tgt;
  end

  // Registered bus request: one-cycle bstart, address held until bdone.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      bstart_q <= 1'b0;
      ss_q     <= 1'b0;
      addr_q   <= RESET_PC;
    end else begin
      bstart_q <= (state_d == ST_ISSUE);
      ss_q     <= (state_d != ST_IDLE);
      if (state_d == ST_ISSUE) addr_q <= fetch_pc_d;
    end
  end

`ifdef FETCH_PERF_EN
  // Words pushed and decoder-starved cycles; unaffected by redirect.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      perf_fetched <= '0;
      perf_stall   <= '0;
    end else begin
      if (push) perf_fetched <= perf_fetched + 32'd1;
      if (instr_ready && !instr_valid) perf_stall <= perf_stall + 32'd1;
    end
  end
`endif

endmodule

// File: tb/tb_fetch_unit.sv
// Bench for fetch_unit: memory slave model, in-order stream model, directed steps.
module tb_fetch_unit;

  logic        clk = 1'b0;
  logic        rst_n;
  logic        redirect_valid;
  logic [31:0] redirect_pc;
  logic        instr_valid;
  logic [31:0] instr;
  logic [31:0] instr_pc;
  logic        instr_ready;
`ifdef FETCH_PERF_EN
  logic [31:0] perf_fetched;
  logic [31:0] perf_stall;
`endif

  always #5 clk = ~clk;

  master_bus_if ibus ();

  fetch_unit #(.RESET_PC(32'h0000_0000), .DEPTH(4)) dut (
    .clk            (clk),
    .rst_n          (rst_n),
    .ibus           (ibus),
    .redirect_valid (redirect_valid),
    .redirect_pc    (redirect_pc),
    .instr_valid    (instr_valid),
    .instr          (instr),
    .instr_pc       (instr_pc),
    .instr_ready    (instr_ready)
`ifdef FETCH_PERF_EN
    ,
    .perf_fetched   (perf_fetched),
    .perf_stall     (perf_stall)
`endif
  );

  int unsigned n_pass  = 0;
  int unsigned n_total = 0;

  // Memory contents: word n holds (n+1)*0x11.
  function automatic logic [31:0] mem_word(input logic [31:0] a);
    logic [31:0] w;
    w = (a >> 2) + 32'd1;
    return w * 32'h11;
  endfunction

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_total++;
    assert (obs === exp) n_pass++;
    else $error("FAIL %s: observed %h expected %h", tag, obs, exp);
  endtask

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  // Memory slave: fixed or random latency, bdone one cycle with rdata.
  int          fixed_lat = 1;
  bit          rand_lat  = 1'b0;
  logic        pending;
  int          cnt;
  logic [31:0] addr_l;
  logic [31:0] last_addr;
  int          bstart_cnt;
  int          overlap_err = 0;

  always @(negedge clk) begin
    if (!rst_n) begin
      pending    = 1'b0;
      ibus.bdone = 1'b0;
      ibus.rdata = '0;
      bstart_cnt = 0;
      cnt        = 0;
    end else begin
      if (ibus.bdone) begin
        ibus.bdone = 1'b0;
        pending    = 1'b0;
      end
      if (pending) begin
        cnt--;
        if (cnt == 0) begin
          ibus.bdone = 1'b1;
          ibus.rdata = mem_word(addr_l);
          chk("addr_stable", ibus.addr, addr_l);
        end
      end
      if (ibus.bstart) begin
        if (pending) overlap_err++;
        pending    = 1'b1;
        cnt        = rand_lat ? int'($urandom_range(4, 1)) : fixed_lat;
        addr_l     = ibus.addr;
        last_addr  = ibus.addr;
        bstart_cnt++;
      end
    end
  end

  // Stream model: consumed words must follow the current target sequentially.
  logic [31:0] model_pc;
  int          pops;
  int          stall_m;

  always @(negedge clk) begin
    #2;
    if (!rst_n) begin
      model_pc = 32'h0;
      pops     = 0;
      stall_m  = 0;
    end else begin
      if (instr_ready && !instr_valid) stall_m++;
      if (redirect_valid) begin
        model_pc = redirect_pc & ~32'h3;
      end else if (instr_valid && instr_ready) begin
        chk("stream_pc", instr_pc, model_pc);
        chk("stream_instr", instr, mem_word(model_pc));
        model_pc = model_pc + 32'd4;
        pops++;
      end
    end
  end

  task automatic do_reset(input logic rdy);
    rst_n       = 1'b0;
    instr_ready = rdy;
    step();
    step();
    rst_n = 1'b1;
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog: simulation did not finish");
    $fatal(1);
  end

  initial begin
    bit found;
    logic [31:0] f0;
    rst_n          = 1'b0;
    redirect_valid = 1'b0;
    redirect_pc    = '0;
    instr_ready    = 1'b1;
    repeat (3) step();

    // Reset values.
    chk("rst_valid",  32'(instr_valid), 32'd0);
    chk("rst_bstart", 32'(ibus.bstart), 32'd0);
    chk("rst_ss",     32'(ibus.ss), 32'd0);
    chk("rst_addr",   ibus.addr, 32'h0);
    chk("rst_instr",  instr, 32'h0);
    chk("rst_pc",     instr_pc, 32'h0);

    // First fetch: ISSUE, WAIT, then head visible on cycle 3.
    rst_n = 1'b1;
    step();
    chk("c1_bstart", 32'(ibus.bstart), 32'd1);
    chk("c1_addr",   ibus.addr, 32'h0);
    chk("c1_ss",     32'(ibus.ss), 32'd1);
    chk("c1_valid",  32'(instr_valid), 32'd0);
    step();
    chk("c2_bstart", 32'(ibus.bstart), 32'd0);
    chk("c2_valid",  32'(instr_valid), 32'd0);
    step();
    chk("c3_valid",  32'(instr_valid), 32'd1);
    chk("c3_instr",  instr, 32'h11);
    chk("c3_pc",     instr_pc, 32'h0);
    for (int i = 0; i < 40 && pops < 4; i++) step();
    chk("four_words", 32'(pops >= 4), 32'd1);

    // Decoder stalled: exactly DEPTH requests, then one pop refills from 0x10.
    do_reset(1'b0);
    repeat (30) step();
    chk("full_bstarts", 32'(bstart_cnt), 32'd4);
    chk("full_valid",   32'(instr_valid), 32'd1);
    chk("full_head_pc", instr_pc, 32'h0);
    repeat (5) step();
    chk("full_hold",    32'(bstart_cnt), 32'd4);
    instr_ready = 1'b1;
    step();
    instr_ready = 1'b0;
    repeat (10) step();
    chk("refill_bstarts", 32'(bstart_cnt), 32'd5);
    chk("refill_addr",    last_addr, 32'h10);
    chk("refill_head",    instr_pc, 32'h4);

    // Redirect while waiting on a slow response: drop it, restart at 0x100.
    fixed_lat   = 3;
    instr_ready = 1'b1;
    for (int i = 0; i < 20 && !ibus.bstart; i++) step();
    chk("t3_issue_seen", 32'(ibus.bstart), 32'd1);
    step();
    redirect_valid = 1'b1;
    redirect_pc    = 32'h103;
    step();
    redirect_valid = 1'b0;
    chk("t3_flushed", 32'(instr_valid), 32'd0);
    found = 1'b0;
    for (int i = 0; i < 40; i++) begin
      if (instr_valid) begin
        found = 1'b1;
        break;
      end
      step();
    end
    chk("t3_valid_seen", 32'(found), 32'd1);
    chk("t3_pc",    instr_pc, 32'h100);
    chk("t3_instr", instr, mem_word(32'h100));

    // Redirect coinciding with bdone and a pop on a non-empty FIFO.
    fixed_lat = 1;
    do_reset(1'b0);
    found = 1'b0;
    for (int i = 0; i < 30; i++) begin
      @(negedge clk);
      #1;
      if (ibus.bdone && instr_valid) begin
        found = 1'b1;
        break;
      end
    end
    chk("t4_setup", 32'(found), 32'd1);
    redirect_valid = 1'b1;
    redirect_pc    = 32'h200;
    instr_ready    = 1'b1;
    step();
    redirect_valid = 1'b0;
    instr_ready    = 1'b0;
    chk("t4_empty",  32'(instr_valid), 32'd0);
    chk("t4_bstart", 32'(ibus.bstart), 32'd1);
    chk("t4_addr",   ibus.addr, 32'h200);

    // Address wrap at the top of memory.
    instr_ready    = 1'b1;
    redirect_valid = 1'b1;
    redirect_pc    = 32'hFFFF_FFFC;
    step();
    redirect_valid = 1'b0;
    for (int i = 0; i < 30 && !(ibus.bstart && ibus.addr == 32'hFFFF_FFFC); i++) step();
    chk("t5_top_issue", ibus.addr, 32'hFFFF_FFFC);
    step();
    for (int i = 0; i < 20 && !ibus.bstart; i++) step();
    chk("t5_wrap_bstart", 32'(ibus.bstart), 32'd1);
    chk("t5_wrap_addr",   ibus.addr, 32'h0);
    repeat (10) step();

    // Random traffic: latency, ready and redirects all randomized.
    rand_lat = 1'b1;
    for (int i = 0; i < 400; i++) begin
      instr_ready    = ($urandom % 4) != 0;
      redirect_valid = ($urandom % 30) == 0;
      redirect_pc    = $urandom;
      step();
    end
    redirect_valid = 1'b0;
    instr_ready    = 1'b1;
    repeat (30) step();
    chk("rand_progress", 32'(pops > 50), 32'd1);

`ifdef FETCH_PERF_EN
    // Performance counters.
    rand_lat = 1'b0;
    do_reset(1'b0);
    repeat (30) step();
    chk("perf_fetched4", perf_fetched, 32'd4);
    chk("perf_stall0",   perf_stall, 32'd0);
    f0             = perf_fetched;
    redirect_valid = 1'b1;
    redirect_pc    = 32'h40;
    step();
    redirect_valid = 1'b0;
    chk("perf_keep", perf_fetched, f0);
    instr_ready = 1'b1;
    repeat (20) step();
    chk("perf_stall_model", perf_stall, 32'(stall_m));
    chk("perf_grew", 32'(perf_fetched > f0), 32'd1);
`else
    f0 = '0;
`endif

    chk("no_overlap", 32'(overlap_err), 32'd0);
    $display("%0d/%0d checks passed", n_pass, n_total);
    $finish;
  end

endmodule
